// File: rtl/slave_mem.sv
// slave_mem: crossbar slave endpoint backed by a 2**ADDR_W x 32 word memory.
// Handshake: slave_req held until a one-cycle slave_ack; reads return data
// on slave_rdata the cycle after the ack.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (clears memory too)
//   slave_req    request, held high until acknowledged
//   slave_addr   byte address, word index = slave_addr[ADDR_W+1:2]
//   slave_cmd    0 = read, 1 = write
//   slave_wdata  write data, captured together with the address
//   slave_ack    one-cycle acceptance pulse
//   slave_rdata  read data, held until the next read completes
//   rd_cnt       completed reads (wraps)
//   wr_cnt       completed writes (wraps)
//   proto_err    one-cycle pulse when req is withdrawn before completion
module slave_mem #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slave_req,
    input  logic [31:0] slave_addr,
    input  logic        slave_cmd,
    input  logic [31:0] slave_wdata,
    output logic        slave_ack,
    output logic [31:0] slave_rdata,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic        proto_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] cap_idx;
    logic              cap_cmd;
    logic [31:0]       cap_wdata;
    logic [31:0]       mem [DEPTH];

    // Address bits outside the word index are aliased away.
    logic unused_addr;
    assign unused_addr = ^{slave_addr[31:ADDR_W+2], slave_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cap_idx     <= '0;
            cap_cmd     <= 1'b0;
            cap_wdata   <= '0;
            slave_ack   <= 1'b0;
            slave_rdata <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            proto_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            slave_ack <= 1'b0;
            proto_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (slave_req) begin
                        cap_idx   <= slave_addr[ADDR_W+1:2];
                        cap_cmd   <= slave_cmd;
                        cap_wdata <= slave_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state     <= S_ACK;
                            slave_ack <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!slave_req) begin
                        state     <= S_IDLE;
                        proto_err <= 1'b1;
                    end else if (wait_cnt == 4'd1) begin
                        // Counter reaches zero on this edge: ack next cycle.
                        state     <= S_ACK;
                        wait_cnt  <= '0;
                        slave_ack <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    // Completion edge; req is not re-sampled for a new
                    // transaction here, so back-to-back is one per
                    // WAIT_CYCLES+2 cycles.
                    state <= S_IDLE;
                    if (!slave_req) begin
                        proto_err <= 1'b1;
                    end else if (cap_cmd) begin
                        mem[cap_idx] <= cap_wdata;
                        wr_cnt       <= wr_cnt + 16'd1;
                    end else begin
                        slave_rdata <= mem[cap_idx];
                        rd_cnt      <= rd_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_mem.sv
// tb_slave_mem: directed bench for slave_mem (WAIT_CYCLES=2 main instance,
// WAIT_CYCLES=0 instance for the counter-wrap run).
module tb_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        slave_req;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [31:0] slave_wdata;
    logic        slave_ack;
    logic [31:0] slave_rdata;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        proto_err;

    logic        f_req;
    logic [31:0] f_addr;
    logic        f_cmd;
    logic [31:0] f_wdata;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic [15:0] f_rd_cnt;
    logic [15:0] f_wr_cnt;
    logic        f_perr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slave_mem #(.ADDR_W(6), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .slave_req   (slave_req),
        .slave_addr  (slave_addr),
        .slave_cmd   (slave_cmd),
        .slave_wdata (slave_wdata),
        .slave_ack   (slave_ack),
        .slave_rdata (slave_rdata),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .proto_err   (proto_err)
    );

    slave_mem #(.ADDR_W(6), .WAIT_CYCLES(0)) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .slave_req   (f_req),
        .slave_addr  (f_addr),
        .slave_cmd   (f_cmd),
        .slave_wdata (f_wdata),
        .slave_ack   (f_ack),
        .slave_rdata (f_rdata),
        .rd_cnt      (f_rd_cnt),
        .wr_cnt      (f_wr_cnt),
        .proto_err   (f_perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full WAIT_CYCLES=2 transaction; inputs are scrambled after E0
    // so only the captured values may take effect.
    task automatic txn(input logic cmd, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
        slave_req   = 1'b1;
        slave_cmd   = cmd;
        slave_addr  = addr;
        slave_wdata = wdata;
        tick;
        chk({tag, "_ack_e0"}, {31'b0, slave_ack}, 32'd0);
        slave_cmd   = ~cmd;
        slave_addr  = ~addr;
        slave_wdata = ~wdata;
        tick;
        chk({tag, "_ack_e1"}, {31'b0, slave_ack}, 32'd0);
        tick;
        chk({tag, "_ack_e2"}, {31'b0, slave_ack}, 32'd1);
        tick;
        chk({tag, "_ack_e3"}, {31'b0, slave_ack}, 32'd0);
        slave_req = 1'b0;
    endtask

    initial begin
        int t_ack[3];
        int nacks;
        logic [31:0] b2b_data[3];

        b2b_data[0] = 32'h0000_0001;
        b2b_data[1] = 32'h0000_0002;
        b2b_data[2] = 32'h0000_0003;

        reset       = 1'b1;
        slave_req   = 1'b1;
        slave_addr  = 32'h0000_0010;
        slave_cmd   = 1'b1;
        slave_wdata = 32'hFFFF_FFFF;
        f_req       = 1'b0;
        f_addr      = '0;
        f_cmd       = 1'b0;
        f_wdata     = '0;
        tick;
        tick;
        chk("rst_ack",   {31'b0, slave_ack}, 32'd0);
        chk("rst_perr",  {31'b0, proto_err}, 32'd0);
        chk("rst_rdata", slave_rdata, 32'd0);
        chk("rst_rdcnt", {16'b0, rd_cnt}, 32'd0);
        chk("rst_wrcnt", {16'b0, wr_cnt}, 32'd0);
        slave_req = 1'b0;
        reset     = 1'b0;

        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, "wr10");
        chk("wr10_wrcnt", {16'b0, wr_cnt}, 32'd1);
        chk("wr10_rdcnt", {16'b0, rd_cnt}, 32'd0);

        txn(1'b0, 32'h0000_0010, 32'h0, "rd10");
        chk("rd10_rdata", slave_rdata, 32'hDEAD_BEEF);
        chk("rd10_rdcnt", {16'b0, rd_cnt}, 32'd1);

        txn(1'b1, 32'h0000_0018, 32'hA5A5_A5A5, "wr18");
        chk("wr18_hold_rdata", slave_rdata, 32'hDEAD_BEEF);
        chk("wr18_wrcnt", {16'b0, wr_cnt}, 32'd2);

        txn(1'b0, 32'h0000_0014, 32'h0, "rd14");
        chk("rd14_rdata", slave_rdata, 32'h0000_0000);
        chk("rd14_rdcnt", {16'b0, rd_cnt}, 32'd2);

        // Abort: drop req after one WAIT cycle.
        slave_req   = 1'b1;
        slave_cmd   = 1'b1;
        slave_addr  = 32'h0000_0020;
        slave_wdata = 32'h0000_0055;
        tick;
        tick;
        slave_req = 1'b0;
        tick;
        chk("abort_ack",  {31'b0, slave_ack}, 32'd0);
        chk("abort_perr", {31'b0, proto_err}, 32'd1);
        tick;
        chk("abort_perr_off", {31'b0, proto_err}, 32'd0);
        chk("abort_ack2", {31'b0, slave_ack}, 32'd0);
        chk("abort_wrcnt", {16'b0, wr_cnt}, 32'd2);
        chk("abort_rdcnt", {16'b0, rd_cnt}, 32'd2);
        txn(1'b0, 32'h0000_0020, 32'h0, "rd20");
        chk("rd20_rdata", slave_rdata, 32'h0000_0000);

        // Three back-to-back writes with req held.
        nacks       = 0;
        slave_req   = 1'b1;
        slave_cmd   = 1'b1;
        slave_addr  = 32'h0000_0040;
        slave_wdata = b2b_data[0];
        for (int i = 0; i < 40 && nacks < 3; i++) begin
            tick;
            if (slave_ack) begin
                t_ack[nacks] = cyc;
                nacks++;
                if (nacks < 3) begin
                    slave_addr  = 32'h0000_0040 + 32'(nacks * 4);
                    slave_wdata = b2b_data[nacks];
                end
            end
        end
        chk("b2b_nacks", 32'(nacks), 32'd3);
        tick;
        slave_req = 1'b0;
        if (nacks == 3) begin
            chk("b2b_gap1", 32'(t_ack[1] - t_ack[0]), 32'd4);
            chk("b2b_gap2", 32'(t_ack[2] - t_ack[1]), 32'd4);
        end
        chk("b2b_wrcnt", {16'b0, wr_cnt}, 32'd5);
        txn(1'b0, 32'h0000_0044, 32'h0, "rd44");
        chk("rd44_rdata", slave_rdata, 32'h0000_0002);
        txn(1'b0, 32'h7F00_004B, 32'h0, "alias48");
        chk("alias48_rdata", slave_rdata, 32'h0000_0003);
        chk("alias48_rdcnt", {16'b0, rd_cnt}, 32'd5);

        // Reset during WAIT of a write.
        slave_req   = 1'b1;
        slave_cmd   = 1'b1;
        slave_addr  = 32'h0000_0030;
        slave_wdata = 32'h0000_0077;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("midrst_ack",   {31'b0, slave_ack}, 32'd0);
        chk("midrst_perr",  {31'b0, proto_err}, 32'd0);
        chk("midrst_rdata", slave_rdata, 32'd0);
        chk("midrst_rdcnt", {16'b0, rd_cnt}, 32'd0);
        chk("midrst_wrcnt", {16'b0, wr_cnt}, 32'd0);
        tick;
        chk("midrst_ack_held", {31'b0, slave_ack}, 32'd0);
        slave_req = 1'b0;
        reset     = 1'b0;
        tick;
        chk("postrst_ack", {31'b0, slave_ack}, 32'd0);
        txn(1'b0, 32'h0000_0030, 32'h0, "rd30");
        chk("rd30_rdata", slave_rdata, 32'h0000_0000);
        txn(1'b0, 32'h0000_0010, 32'h0, "rd10_cleared");
        chk("rd10c_rdata", slave_rdata, 32'h0000_0000);
        chk("rd10c_rdcnt", {16'b0, rd_cnt}, 32'd2);
        chk("rd10c_wrcnt", {16'b0, wr_cnt}, 32'd0);

        // Counter wrap on the zero-wait instance: 65535 writes held
        // back-to-back at one per two cycles, then one more.
        f_req   = 1'b1;
        f_cmd   = 1'b1;
        f_addr  = 32'h0000_0000;
        f_wdata = 32'h1111_1111;
        tick;
        chk("fast_ack_e0", {31'b0, f_ack}, 32'd1);
        repeat (131069) tick;
        f_req = 1'b0;
        tick;
        chk("wrap_ffff", {16'b0, f_wr_cnt}, 32'h0000_FFFF);
        f_req   = 1'b1;
        f_wdata = 32'h0BAD_F00D;
        tick;
        chk("wrap_ack", {31'b0, f_ack}, 32'd1);
        tick;
        f_req = 1'b0;
        chk("wrap_zero", {16'b0, f_wr_cnt}, 32'h0000_0000);
        f_req = 1'b1;
        f_cmd = 1'b0;
        tick;
        tick;
        f_req = 1'b0;
        chk("fast_rdata", f_rdata, 32'h0BAD_F00D);
        chk("fast_rdcnt", {16'b0, f_rd_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
